// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter between the core data port (m0) and the UART loader (m1),
// decoding byte addresses onto the text/data/stack RAMs or the UART registers.
//
// state      | meaning
// -----------+--------------------------------------------------------
// S_IDLE     | waiting for a request; grant and latch happen here
// S_ACCESS   | one-cycle RAM strobe from the latched request
// S_RESP     | rvalid with synchronous RAM read data
// S_IO       | io_req held until io_ack or timeout
// S_RESP_IO  | rvalid with captured UART read data
// S_RESP_ERR | rvalid with err (unmapped, protection fault, IO timeout)
`timescale 1ns/1ps
module mem_bus_arbiter #(
  parameter int          IDX_W     = 10,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] STACK_TOP = 32'h7FFF_EFFC,
  parameter logic [31:0] STACK_IDX = 32'h0000_0040
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [31:0]      m0_rdata,
  output logic             m0_err,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [31:0]      m1_rdata,
  output logic             m1_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [1:0]       mem_sel,
  output logic [IDX_W-1:0] mem_idx,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             io_req,
  output logic             io_we,
  output logic [1:0]       io_reg,
  output logic [31:0]      io_wdata,
  input  logic             io_ack,
  input  logic [31:0]      io_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCESS, S_RESP, S_IO, S_RESP_IO, S_RESP_ERR
  } state_t;

  state_t state, state_nxt;

  logic             last_m1;
  logic             lat_m1;
  logic             lat_we;
  logic [31:0]      lat_wdata;
  logic [1:0]       lat_sel;
  logic [IDX_W-1:0] lat_idx;
  logic [1:0]       lat_reg;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      io_data;

  logic             gnt0, gnt1, gnt_any;
  logic             req_we;
  logic [31:0]      req_addr, req_wdata;
  logic             dec_io, dec_ram, dec_fault;
  logic [1:0]       dec_sel;
  logic [IDX_W-1:0] dec_idx;

  logic             resp_valid, resp_err;
  logic [31:0]      resp_data;

  // Arbitration: on contention the master not served last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == S_IDLE && reset) begin
      if (m0_req && (!m1_req || last_m1)) gnt0 = 1'b1;
      else if (m1_req)                    gnt1 = 1'b1;
    end
    gnt_any   = gnt0 | gnt1;
    req_we    = gnt1 ? m1_we    : m0_we;
    req_addr  = gnt1 ? m1_addr  : m0_addr;
    req_wdata = gnt1 ? m1_wdata : m0_wdata;
  end

  // Region decode, first match wins; index math wraps at 32 bits.
  always_comb begin
    dec_io  = 1'b0;
    dec_ram = 1'b0;
    dec_sel = 2'd0;
    dec_idx = '0;
    if (req_addr >= 32'hFFFF_0000 && req_addr <= 32'hFFFF_000F) begin
      dec_io = 1'b1;
    end else if (req_addr >= 32'h0040_0000 && req_addr <= 32'h1000_FFFF) begin
      dec_ram = 1'b1;
      dec_sel = 2'd0;
      dec_idx = IDX_W'((req_addr - 32'h0040_0000) >> 2);
    end else if (req_addr >= 32'h1001_0000 && req_addr <= 32'h1001_FFFF) begin
      dec_ram = 1'b1;
      dec_sel = 2'd1;
      dec_idx = IDX_W'((req_addr - 32'h1001_0000) >> 2);
    end else if (req_addr > 32'h7F00_0000 && req_addr <= 32'h7FFF_FFFF) begin
      dec_ram = 1'b1;
      dec_sel = 2'd2;
      dec_idx = IDX_W'(STACK_IDX - ((STACK_TOP - req_addr) >> 2));
    end
    dec_fault = dec_ram && (dec_sel == 2'd0) && req_we && !gnt1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (gnt_any) begin
          if (dec_io)                      state_nxt = S_IO;
          else if (dec_ram && !dec_fault)  state_nxt = S_ACCESS;
          else                             state_nxt = S_RESP_ERR;
        end
      end
      S_ACCESS:   state_nxt = S_RESP;
      S_RESP:     state_nxt = S_IDLE;
      S_IO: begin
        // An ack on the final allowed cycle still counts as success.
        if (io_ack)                            state_nxt = S_RESP_IO;
        else if (cnt == CNT_W'(TIMEOUT - 1))   state_nxt = S_RESP_ERR;
      end
      S_RESP_IO:  state_nxt = S_IDLE;
      S_RESP_ERR: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_m1   <= 1'b1;
      lat_m1    <= 1'b0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      lat_sel   <= '0;
      lat_idx   <= '0;
      lat_reg   <= '0;
      cnt       <= '0;
      io_data   <= '0;
    end else if (gnt_any) begin
      last_m1   <= gnt1;
      lat_m1    <= gnt1;
      lat_we    <= req_we;
      lat_wdata <= req_wdata;
      lat_sel   <= dec_sel;
      lat_idx   <= dec_idx;
      lat_reg   <= req_addr[3:2];
      cnt       <= '0;
    end else if (state == S_IO) begin
      cnt <= cnt + CNT_W'(1);
      if (io_ack) io_data <= io_rdata;
    end
  end

  always_comb begin
    m0_gnt     = gnt0;
    m1_gnt     = gnt1;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_sel    = '0;
    mem_idx    = '0;
    mem_wdata  = '0;
    io_req     = 1'b0;
    io_we      = 1'b0;
    io_reg     = '0;
    io_wdata   = '0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;
    case (state)
      S_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        mem_sel   = lat_sel;
        mem_idx   = lat_idx;
        mem_wdata = lat_wdata;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_data  = lat_we ? 32'd0 : mem_rdata;
      end
      S_IO: begin
        io_req   = 1'b1;
        io_we    = lat_we;
        io_reg   = lat_reg;
        io_wdata = lat_wdata;
      end
      S_RESP_IO: begin
        resp_valid = 1'b1;
        resp_data  = lat_we ? 32'd0 : io_data;
      end
      S_RESP_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
      end
      default: ;
    endcase
    m0_rvalid = resp_valid && !lat_m1;
    m0_err    = resp_err   && !lat_m1;
    m0_rdata  = lat_m1 ? 32'd0 : resp_data;
    m1_rvalid = resp_valid && lat_m1;
    m1_err    = resp_err   && lat_m1;
    m1_rdata  = lat_m1 ? resp_data : 32'd0;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: decode, round-robin, protection,
// IO handshake/timeout and asynchronous reset behaviour.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_rdata;
  logic        mem_en, mem_we;
  logic [1:0]  mem_sel;
  logic [9:0]  mem_idx;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        io_req, io_we;
  logic [1:0]  io_reg;
  logic [31:0] io_wdata;
  logic        io_ack = 1'b0;
  logic [31:0] io_rdata = '0;
  logic [151:0] all_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_sel(mem_sel), .mem_idx(mem_idx),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .io_req(io_req), .io_we(io_we), .io_reg(io_reg), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata)
  );

  assign all_out = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
                    m0_err, m1_err, mem_en, mem_we, mem_sel, mem_idx, mem_wdata,
                    io_req, io_we, io_reg, io_wdata};

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic test_reset();
    m0_req = 1'b1; m0_addr = 32'h1001_0000;
    #12;
    n_checks++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL reset_outputs actual=%h expected=0", all_out);
    end
    m0_req = 1'b0;
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_m0_read();
    next_cycle();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1001_0008; mem_rdata = 32'hCAFE_0001;
    mid();
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL m0_read_gnt actual=%b expected=10", {m0_gnt, m1_gnt});
    end
    next_cycle(); m0_req = 1'b0;
    mid();
    n_checks++;
    if ({mem_en, mem_we, mem_sel, mem_idx, m0_rvalid} !== {1'b1, 1'b0, 2'd1, 10'd2, 1'b0}) begin
      n_fail++; $display("FAIL m0_read_access actual=%h expected=%h",
                         {mem_en, mem_we, mem_sel, mem_idx, m0_rvalid}, {1'b1, 1'b0, 2'd1, 10'd2, 1'b0});
    end
    next_cycle(); mid();
    n_checks++;
    if ({m0_rvalid, m0_err, m0_rdata, mem_en, m1_rvalid} !== {1'b1, 1'b0, 32'hCAFE_0001, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL m0_read_resp actual=%h expected=%h",
                         {m0_rvalid, m0_err, m0_rdata, mem_en, m1_rvalid}, {1'b1, 1'b0, 32'hCAFE_0001, 2'b00});
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_gnt [12] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00,
                                 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    next_cycle(); reset = 1'b0;
    next_cycle(); reset = 1'b1;
    next_cycle();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1001_0000; mem_rdata = 32'h0BAD_0000;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0040_0010; m1_wdata = 32'h1234_5678;
    mid();
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL contend_first_gnt actual=%b expected=10", {m0_gnt, m1_gnt});
    end
    next_cycle(); m0_req = 1'b0;
    mid();
    n_checks++;
    if ({m1_gnt, mem_en, mem_sel} !== {1'b0, 1'b1, 2'd1}) begin
      n_fail++; $display("FAIL contend_m0_access actual=%b expected=0101", {m1_gnt, mem_en, mem_sel});
    end
    next_cycle(); mid();
    n_checks++;
    if ({m0_rvalid, m1_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL contend_m0_resp actual=%b expected=10", {m0_rvalid, m1_gnt});
    end
    next_cycle(); mid();
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL contend_m1_gnt actual=%b expected=01", {m0_gnt, m1_gnt});
    end
    next_cycle(); m1_req = 1'b0;
    mid();
    n_checks++;
    if ({mem_en, mem_we, mem_sel, mem_idx, mem_wdata} !== {1'b1, 1'b1, 2'd0, 10'd4, 32'h1234_5678}) begin
      n_fail++; $display("FAIL contend_m1_access actual=%h expected=%h",
                         {mem_en, mem_we, mem_sel, mem_idx, mem_wdata}, {1'b1, 1'b1, 2'd0, 10'd4, 32'h1234_5678});
    end
    next_cycle(); mid();
    n_checks++;
    if ({m1_rvalid, m1_err, m1_rdata, m0_rvalid} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      n_fail++; $display("FAIL contend_m1_resp actual=%h expected=%h",
                         {m1_rvalid, m1_err, m1_rdata, m0_rvalid}, {1'b1, 1'b0, 32'd0, 1'b0});
    end
    next_cycle();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1001_0000;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h1001_0004;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) next_cycle();
      mid();
      n_checks++;
      if ({m0_gnt, m1_gnt} !== exp_gnt[i]) begin
        n_fail++; $display("FAIL alternate_gnt cycle=%0d actual=%b expected=%b", i, {m0_gnt, m1_gnt}, exp_gnt[i]);
      end
    end
    next_cycle(); m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_protection();
    next_cycle();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0040_0000; m0_wdata = 32'hDEAD_BEEF;
    mid();
    n_checks++;
    if (m0_gnt !== 1'b1) begin
      n_fail++; $display("FAIL prot_m0_gnt actual=%b expected=1", m0_gnt);
    end
    next_cycle(); m0_req = 1'b0;
    mid();
    n_checks++;
    if ({m0_rvalid, m0_err, m0_rdata, mem_en} !== {1'b1, 1'b1, 32'd0, 1'b0}) begin
      n_fail++; $display("FAIL prot_m0_fault actual=%h expected=%h",
                         {m0_rvalid, m0_err, m0_rdata, mem_en}, {1'b1, 1'b1, 32'd0, 1'b0});
    end
    next_cycle();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0040_0000; m1_wdata = 32'hDEAD_BEEF;
    mid();
    n_checks++;
    if (m1_gnt !== 1'b1) begin
      n_fail++; $display("FAIL prot_m1_gnt actual=%b expected=1", m1_gnt);
    end
    next_cycle(); m1_req = 1'b0;
    mid();
    n_checks++;
    if ({mem_en, mem_we, mem_sel, mem_idx, mem_wdata} !== {1'b1, 1'b1, 2'd0, 10'd0, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL prot_m1_access actual=%h expected=%h",
                         {mem_en, mem_we, mem_sel, mem_idx, mem_wdata}, {1'b1, 1'b1, 2'd0, 10'd0, 32'hDEAD_BEEF});
    end
    next_cycle(); mid();
    n_checks++;
    if ({m1_rvalid, m1_err} !== 2'b10) begin
      n_fail++; $display("FAIL prot_m1_resp actual=%b expected=10", {m1_rvalid, m1_err});
    end
  endtask

  task automatic test_stack();
    logic [31:0] addr_tab [2] = '{32'h7FFF_EFFC, 32'h7FFF_EFF8};
    logic [9:0]  idx_tab  [2] = '{10'h040, 10'h03F};
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = addr_tab[i]; mem_rdata = 32'h5AC0_0000 + i;
      next_cycle(); m0_req = 1'b0;
      mid();
      n_checks++;
      if ({mem_en, mem_sel, mem_idx} !== {1'b1, 2'd2, idx_tab[i]}) begin
        n_fail++; $display("FAIL stack_idx addr=%h actual=%h expected=%h",
                           addr_tab[i], {mem_en, mem_sel, mem_idx}, {1'b1, 2'd2, idx_tab[i]});
      end
      next_cycle(); mid();
      n_checks++;
      if ({m0_rvalid, m0_err, m0_rdata} !== {1'b1, 1'b0, 32'h5AC0_0000 + i}) begin
        n_fail++; $display("FAIL stack_resp addr=%h actual=%h", addr_tab[i], {m0_rvalid, m0_err, m0_rdata});
      end
    end
  endtask

  task automatic test_io_ack();
    next_cycle();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'hFFFF_0004;
    mid();
    n_checks++;
    if (m0_gnt !== 1'b1) begin
      n_fail++; $display("FAIL io_gnt actual=%b expected=1", m0_gnt);
    end
    next_cycle(); m0_req = 1'b0;
    mid();
    n_checks++;
    if ({io_req, io_we, io_reg, mem_en} !== {1'b1, 1'b0, 2'd1, 1'b0}) begin
      n_fail++; $display("FAIL io_req_start actual=%b expected=10010", {io_req, io_we, io_reg, mem_en});
    end
    next_cycle(); next_cycle(); next_cycle();
    next_cycle(); io_ack = 1'b1; io_rdata = 32'hA5A5_0004;
    mid();
    n_checks++;
    if ({io_req, m0_rvalid} !== 2'b10) begin
      n_fail++; $display("FAIL io_req_held actual=%b expected=10", {io_req, m0_rvalid});
    end
    next_cycle(); io_ack = 1'b0; io_rdata = '0;
    mid();
    n_checks++;
    if ({m0_rvalid, m0_err, m0_rdata, io_req} !== {1'b1, 1'b0, 32'hA5A5_0004, 1'b0}) begin
      n_fail++; $display("FAIL io_resp actual=%h expected=%h",
                         {m0_rvalid, m0_err, m0_rdata, io_req}, {1'b1, 1'b0, 32'hA5A5_0004, 1'b0});
    end
  endtask

  task automatic test_io_timeout();
    int  hi = 0;
    bit  done = 1'b0;
    next_cycle();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'hFFFF_0008;
    mid();
    n_checks++;
    if (m1_gnt !== 1'b1) begin
      n_fail++; $display("FAIL timeout_gnt actual=%b expected=1", m1_gnt);
    end
    next_cycle(); m1_req = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (i > 0) next_cycle();
      mid();
      if (io_req) hi++;
      else        done = 1'b1;
    end
    n_checks++;
    if (!done || hi != 255) begin
      n_fail++; $display("FAIL timeout_len actual=%0d cycles expected=255 (ended=%0d)", hi, done);
    end
    n_checks++;
    if ({m1_rvalid, m1_err, m1_rdata, m0_rvalid} !== {1'b1, 1'b1, 32'd0, 1'b0}) begin
      n_fail++; $display("FAIL timeout_resp actual=%h expected=%h",
                         {m1_rvalid, m1_err, m1_rdata, m0_rvalid}, {1'b1, 1'b1, 32'd0, 1'b0});
    end
  endtask

  task automatic test_unmapped();
    next_cycle();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h2000_0000;
    mid();
    n_checks++;
    if (m0_gnt !== 1'b1) begin
      n_fail++; $display("FAIL unmapped_gnt actual=%b expected=1", m0_gnt);
    end
    next_cycle(); m0_req = 1'b0;
    mid();
    n_checks++;
    if ({m0_rvalid, m0_err, m0_rdata, mem_en, io_req} !== {1'b1, 1'b1, 32'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL unmapped_resp actual=%h expected=%h",
                         {m0_rvalid, m0_err, m0_rdata, mem_en, io_req}, {1'b1, 1'b1, 32'd0, 2'b00});
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    next_cycle();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'hFFFF_0000; m1_wdata = 32'h0000_0055;
    next_cycle(); m1_req = 1'b0;
    mid();
    n_checks++;
    if ({io_req, io_we, io_reg, io_wdata} !== {1'b1, 1'b1, 2'd0, 32'h55}) begin
      n_fail++; $display("FAIL midrst_io actual=%h expected=%h",
                         {io_req, io_we, io_reg, io_wdata}, {1'b1, 1'b1, 2'd0, 32'h55});
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (all_out !== '0) begin
      n_fail++; $display("FAIL midrst_outputs actual=%h expected=0", all_out);
    end
    next_cycle(); next_cycle(); reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mid();
      if (m0_rvalid || m1_rvalid || io_req) seen++;
      next_cycle();
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL midrst_no_resp actual=%0d active cycles expected=0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_m0_read();
    test_contention();
    test_protection();
    test_stack();
    test_io_ack();
    test_io_timeout();
    test_unmapped();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
